// File: rtl/data_mem_lsu.sv
// Single-port data memory with a RISC-V style load/store front end.
// Accepts one request at a time and returns a registered response after a fixed latency.
module data_mem_lsu #(
    parameter int DEPTH  = 64,
    parameter int XLEN   = 32,
    parameter int RD_LAT = 1,
    parameter int ABITS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [ABITS-1:0] req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_rdata,
    output logic             resp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int         WBITS     = ABITS - 2;
    localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

    logic [XLEN-1:0] mem [DEPTH];

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] hold_rdata_q, hold_rdata_d;
    logic            hold_err_q, hold_err_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;

    logic [WBITS-1:0] word_idx;
    logic [1:0]       lane;
    logic             is_h, is_w;
    logic             illegal, misaligned, req_err;
    logic             accept, mem_we;
    logic [3:0]       byte_en;
    logic [XLEN-1:0]  wdata_rep;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  load_val;

    // Request decode: the load value reflects memory before this edge's write.
    always_comb begin
        word_idx   = req_addr[ABITS-1:2];
        lane       = req_addr[1:0];
        is_h       = (req_funct3[1:0] == 2'b01);
        is_w       = (req_funct3[1:0] == 2'b10);
        illegal    = req_we ? (req_funct3 > 3'b010)
                            : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
        misaligned = (is_h && lane[0]) || (is_w && (lane != 2'b00));
        req_err    = illegal || misaligned;
        accept     = req_valid && (state_q == IDLE) && !rst;
        mem_we     = accept && req_we && !req_err;

        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
        if (is_h) begin
            byte_en   = lane[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{req_wdata[15:0]}};
        end else if (is_w) begin
            byte_en   = 4'b1111;
            wdata_rep = req_wdata;
        end

        shifted = mem[word_idx] >> {lane, 3'b000};
        case (req_funct3)
            3'b000:  load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            hold_rdata_q <= '0;
            hold_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_rdata_q <= hold_rdata_d;
            hold_err_q   <= hold_err_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Loads with RD_LAT>1 park their result in the hold registers while WAIT counts down.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_rdata_d = hold_rdata_q;
        hold_err_d   = hold_err_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_we || (RD_LAT == 1)) begin
                        state_d      = RESP;
                        resp_rdata_d = (req_we || req_err) ? '0 : load_val;
                        resp_err_d   = req_err;
                    end else begin
                        state_d      = WAIT;
                        cnt_d        = WAIT_INIT;
                        hold_rdata_d = req_err ? '0 : load_val;
                        hold_err_d   = req_err;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_d      = RESP;
                    cnt_d        = 3'd0;
                    resp_rdata_d = hold_rdata_q;
                    resp_err_d   = hold_err_q;
                end else begin
                    cnt_d = 3'(cnt_q - 3'd1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        resp_valid_d = (state_d == RESP);
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = resp_valid_q;
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench driving an RD_LAT=1 and an RD_LAT=3 instance in lockstep
// with hand-computed expected load data, error flags and latencies.
module tb_data_mem_lsu;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        err;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_ready = 1'b1;

    logic        r1_req_ready, r1_resp_valid, r1_resp_err;
    logic [31:0] r1_resp_rdata;
    logic        r3_req_ready, r3_resp_valid, r3_resp_err;
    logic [31:0] r3_resp_rdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_mem_lsu #(.DEPTH(64), .XLEN(32), .RD_LAT(1), .ABITS(8)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r1_req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(r1_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(r1_resp_rdata), .resp_err(r1_resp_err)
    );

    data_mem_lsu #(.DEPTH(64), .XLEN(32), .RD_LAT(3), .ABITS(8)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r3_req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(r3_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(r3_resp_rdata), .resp_err(r3_resp_err)
    );

    // Issues one request to both instances and records each response and its latency (-1 = none).
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                          input logic [31:0] wd,
                          output logic [31:0] d1, output logic e1, output int l1,
                          output logic [31:0] d3, output logic e3, output int l3);
        @(negedge clk);
        for (int n = 0; n < 10 && !(r1_req_ready && r3_req_ready); n++) @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        l1 = -1; l3 = -1; d1 = 32'h0; d3 = 32'h0; e1 = 1'b0; e3 = 1'b0;
        for (int k = 1; k <= 12 && (l1 < 0 || l3 < 0); k++) begin
            @(negedge clk);
            if (l1 < 0 && r1_resp_valid) begin l1 = k; d1 = r1_resp_rdata; e1 = r1_resp_err; end
            if (l3 < 0 && r3_resp_valid) begin l3 = k; d3 = r3_resp_rdata; e3 = r3_resp_err; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d1, d3; logic e1, e3; int l1, l3;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (r1_resp_valid !== 1'b0 || r1_resp_err !== 1'b0 || r1_resp_rdata !== 32'h0 ||
            r3_resp_valid !== 1'b0 || r3_resp_err !== 1'b0 || r3_resp_rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got v=%0b/%0b e=%0b/%0b d=%h/%h, want all zero",
                     r1_resp_valid, r3_resp_valid, r1_resp_err, r3_resp_err, r1_resp_rdata, r3_resp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (r1_req_ready !== 1'b1 || r3_req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %0b/%0b, want 1/1", r1_req_ready, r3_req_ready);
        end
        do_req(1'b1, 3'b010, 8'h10, 32'h11111111, d1, e1, l1, d3, e3, l3);
        // A store presented while reset is high must be ignored.
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 8'h10; req_wdata = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        vectors++;
        if (r1_resp_valid !== 1'b0 || r3_resp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_req_ignored: got valid %0b/%0b, want 0/0", r1_resp_valid, r3_resp_valid);
        end
        req_valid = 1'b0; rst = 1'b0;
        do_req(1'b0, 3'b010, 8'h10, 32'h0, d1, e1, l1, d3, e3, l3);
        vectors++;
        if (d1 !== 32'h11111111 || d3 !== 32'h11111111 || e1 !== 1'b0 || e3 !== 1'b0 || l1 !== 1 || l3 !== 3) begin
            miscompares++;
            $display("[TB] FAIL reset_mem_kept: got d=%h/%h e=%0b/%0b lat=%0d/%0d, want d=11111111 e=0 lat=1/3",
                     d1, d3, e1, e3, l1, l3);
        end
    endtask

    task automatic test_loads();
        vec_t v[8];
        logic [31:0] d1, d3; logic e1, e3; int l1, l3;
        v[0] = '{1'b1, 3'b010, 8'h00, 32'h00FF0FF0, 32'h00000000, 1'b0, "sw_preload_w0"};
        v[1] = '{1'b0, 3'b000, 8'h01, 32'h0, 32'h0000000F, 1'b0, "lb_a1"};
        v[2] = '{1'b0, 3'b100, 8'h02, 32'h0, 32'h000000FF, 1'b0, "lbu_a2"};
        v[3] = '{1'b0, 3'b001, 8'h02, 32'h0, 32'h000000FF, 1'b0, "lh_a2"};
        v[4] = '{1'b0, 3'b000, 8'h02, 32'h0, 32'hFFFFFFFF, 1'b0, "lb_a2_sext"};
        v[5] = '{1'b0, 3'b001, 8'h00, 32'h0, 32'h00000FF0, 1'b0, "lh_a0"};
        v[6] = '{1'b0, 3'b000, 8'h00, 32'h0, 32'hFFFFFFF0, 1'b0, "lb_a0_sext"};
        v[7] = '{1'b0, 3'b010, 8'h00, 32'h0, 32'h00FF0FF0, 1'b0, "lw_a0"};
        foreach (v[i]) begin
            do_req(v[i].we, v[i].f3, v[i].addr, v[i].wd, d1, e1, l1, d3, e3, l3);
            vectors++;
            if (d1 !== v[i].exp || e1 !== v[i].err || l1 !== 1 ||
                d3 !== v[i].exp || e3 !== v[i].err || l3 !== (v[i].we ? 1 : 3)) begin
                miscompares++;
                $display("[TB] FAIL %s: got d=%h/%h e=%0b/%0b lat=%0d/%0d, want d=%h e=%0b lat=1/%0d",
                         v[i].name, d1, d3, e1, e3, l1, l3, v[i].exp, v[i].err, v[i].we ? 1 : 3);
            end
        end
    endtask

    task automatic test_store_lanes();
        vec_t v[7];
        logic [31:0] d1, d3; logic e1, e3; int l1, l3;
        v[0] = '{1'b1, 3'b010, 8'h08, 32'hAA22CC33, 32'h00000000, 1'b0, "sw_preload_w2"};
        v[1] = '{1'b1, 3'b000, 8'h09, 32'h1234565A, 32'h00000000, 1'b0, "sb_a9"};
        v[2] = '{1'b0, 3'b010, 8'h08, 32'h0, 32'hAA225A33, 1'b0, "lw_after_sb"};
        v[3] = '{1'b1, 3'b001, 8'h0A, 32'hFFFFBEEF, 32'h00000000, 1'b0, "sh_a10"};
        v[4] = '{1'b0, 3'b010, 8'h08, 32'h0, 32'hBEEF5A33, 1'b0, "lw_after_sh"};
        v[5] = '{1'b0, 3'b001, 8'h0A, 32'h0, 32'hFFFFBEEF, 1'b0, "lh_a10"};
        v[6] = '{1'b0, 3'b101, 8'h0A, 32'h0, 32'h0000BEEF, 1'b0, "lhu_a10"};
        foreach (v[i]) begin
            do_req(v[i].we, v[i].f3, v[i].addr, v[i].wd, d1, e1, l1, d3, e3, l3);
            vectors++;
            if (d1 !== v[i].exp || e1 !== v[i].err || l1 !== 1 ||
                d3 !== v[i].exp || e3 !== v[i].err || l3 !== (v[i].we ? 1 : 3)) begin
                miscompares++;
                $display("[TB] FAIL %s: got d=%h/%h e=%0b/%0b lat=%0d/%0d, want d=%h e=%0b lat=1/%0d",
                         v[i].name, d1, d3, e1, e3, l1, l3, v[i].exp, v[i].err, v[i].we ? 1 : 3);
            end
        end
    endtask

    task automatic test_errors();
        vec_t v[11];
        logic [31:0] d1, d3; logic e1, e3; int l1, l3;
        v[0]  = '{1'b0, 3'b010, 8'h06, 32'h0, 32'h0, 1'b1, "lw_a6_misaligned"};
        v[1]  = '{1'b1, 3'b001, 8'h03, 32'h0000FFFF, 32'h0, 1'b1, "sh_a3_misaligned"};
        v[2]  = '{1'b0, 3'b010, 8'h00, 32'h0, 32'h00FF0FF0, 1'b0, "lw_w0_unchanged"};
        v[3]  = '{1'b0, 3'b001, 8'h01, 32'h0, 32'h0, 1'b1, "lh_a1_misaligned"};
        v[4]  = '{1'b0, 3'b011, 8'h00, 32'h0, 32'h0, 1'b1, "load_f3_011"};
        v[5]  = '{1'b0, 3'b110, 8'h00, 32'h0, 32'h0, 1'b1, "load_f3_110"};
        v[6]  = '{1'b0, 3'b111, 8'h00, 32'h0, 32'h0, 1'b1, "load_f3_111"};
        v[7]  = '{1'b1, 3'b100, 8'h00, 32'hFFFFFFFF, 32'h0, 1'b1, "store_f3_100"};
        v[8]  = '{1'b1, 3'b010, 8'h02, 32'hFFFFFFFF, 32'h0, 1'b1, "sw_a2_misaligned"};
        v[9]  = '{1'b0, 3'b010, 8'h00, 32'h0, 32'h00FF0FF0, 1'b0, "lw_w0_still"};
        v[10] = '{1'b0, 3'b100, 8'h03, 32'h0, 32'h00000000, 1'b0, "lbu_a3"};
        foreach (v[i]) begin
            do_req(v[i].we, v[i].f3, v[i].addr, v[i].wd, d1, e1, l1, d3, e3, l3);
            vectors++;
            if (d1 !== v[i].exp || e1 !== v[i].err || l1 !== 1 ||
                d3 !== v[i].exp || e3 !== v[i].err || l3 !== (v[i].we ? 1 : 3)) begin
                miscompares++;
                $display("[TB] FAIL %s: got d=%h/%h e=%0b/%0b lat=%0d/%0d, want d=%h e=%0b lat=1/%0d",
                         v[i].name, d1, d3, e1, e3, l1, l3, v[i].exp, v[i].err, v[i].we ? 1 : 3);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        for (int n = 0; n < 10 && !(r1_req_ready && r3_req_ready); n++) @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 8'h08; req_wdata = 32'h0;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            vectors++;
            if (r1_resp_valid !== 1'b1 || r1_resp_rdata !== 32'hBEEF5A33 || r1_resp_err !== 1'b0 ||
                r1_req_ready !== 1'b0 || r3_req_ready !== 1'b0 || r3_resp_valid !== (k >= 3) ||
                (k >= 3 && (r3_resp_rdata !== 32'hBEEF5A33 || r3_resp_err !== 1'b0))) begin
                miscompares++;
                $display("[TB] FAIL hold_cycle%0d: got v=%0b/%0b d=%h/%h e=%0b/%0b rdy=%0b/%0b, want v=1/%0b d=beef5a33 e=0 rdy=0/0",
                         k, r1_resp_valid, r3_resp_valid, r1_resp_rdata, r3_resp_rdata,
                         r1_resp_err, r3_resp_err, r1_req_ready, r3_req_ready, k >= 3);
            end
        end
        // req_valid stays high across the release edge; it must not be taken on that edge.
        resp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (r1_resp_valid !== 1'b0 || r3_resp_valid !== 1'b0 || r1_req_ready !== 1'b1 || r3_req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL hold_release: got v=%0b/%0b rdy=%0b/%0b, want v=0/0 rdy=1/1",
                     r1_resp_valid, r3_resp_valid, r1_req_ready, r3_req_ready);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        for (int n = 0; n < 10 && !(r1_req_ready && r3_req_ready); n++) @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 8'h08;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (r1_resp_valid !== 1'b0 || r3_resp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_in_wait_drop: got v=%0b/%0b, want 0/0", r1_resp_valid, r3_resp_valid);
        end
        rst = 1'b0; resp_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            vectors++;
            if (r1_resp_valid !== 1'b0 || r3_resp_valid !== 1'b0 || r1_req_ready !== 1'b1 || r3_req_ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL rst_in_wait_after%0d: got v=%0b/%0b rdy=%0b/%0b, want v=0/0 rdy=1/1",
                         k, r1_resp_valid, r3_resp_valid, r1_req_ready, r3_req_ready);
            end
        end
    endtask

    task automatic test_wrap();
        vec_t v[4];
        logic [8:0]  full_addr;
        logic [7:0]  wa;
        logic [31:0] d1, d3; logic e1, e3; int l1, l3;
        full_addr = 9'h100 + 9'h0B4;
        wa = full_addr[7:0];
        v[0] = '{1'b1, 3'b010, wa, 32'hBBBBBBBB, 32'h0, 1'b0, "sw_w45"};
        v[1] = '{1'b0, 3'b010, wa, 32'h0, 32'hBBBBBBBB, 1'b0, "lw_wrap_w45"};
        v[2] = '{1'b0, 3'b000, 8'hB7, 32'h0, 32'hFFFFFFBB, 1'b0, "lb_w45_b3"};
        v[3] = '{1'b0, 3'b010, 8'h00, 32'h0, 32'h00FF0FF0, 1'b0, "lw_w0_after_wrap"};
        foreach (v[i]) begin
            do_req(v[i].we, v[i].f3, v[i].addr, v[i].wd, d1, e1, l1, d3, e3, l3);
            vectors++;
            if (d1 !== v[i].exp || e1 !== v[i].err || l1 !== 1 ||
                d3 !== v[i].exp || e3 !== v[i].err || l3 !== (v[i].we ? 1 : 3)) begin
                miscompares++;
                $display("[TB] FAIL %s: got d=%h/%h e=%0b/%0b lat=%0d/%0d, want d=%h e=%0b lat=1/%0d",
                         v[i].name, d1, d3, e1, e3, l1, l3, v[i].exp, v[i].err, v[i].we ? 1 : 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store_lanes();
        test_errors();
        test_hold();
        test_reset_in_wait();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Parameter DEPTH, default 64: number of XLEN-bit words; power of two, at least 4.
REQ-002 Parameter XLEN, fixed at 32: data word width in bits.
REQ-003 Parameter RD_LAT, default 1: load latency in cycles from accept to response; legal range 1..8.
REQ-004 Parameter ABITS, default 8: byte-address width; must equal log2(DEPTH)+2.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 req_valid  in  1  request offered this cycle.
REQ-008 req_ready  out  1  block can accept a request this cycle.
REQ-009 req_we  in  1  1 = store, 0 = load.
REQ-010 req_funct3  in  3  RISC-V size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-011 req_addr  in  ABITS  byte address.
REQ-012 req_wdata  in  32  store data, right-aligned.
REQ-013 resp_valid  out  1  response present.
REQ-014 resp_ready  in  1  consumer takes the response this cycle.
REQ-015 resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-016 resp_err  out  1  request was misaligned or used an illegal funct3.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-019 Decode at accept:
  - word index = req_addr[ABITS-1:2]; lane = req_addr[1:0].
  - Halfword with lane[0]=1 is misaligned.
  - Word with lane!=0 is misaligned.
  - Illegal funct3: 011, 110, 111 for loads; any value above 010 for stores.
REQ-020 A legal store SHALL write on its accept edge, updating only the addressed lanes:
  - SB writes 1 byte lane (req_wdata[7:0]).
  - SH writes lanes {1,0} or {3,2} (req_wdata[15:0]).
  - SW writes all 4 lanes.
  - Unaddressed lanes SHALL keep their prior values.
REQ-021 An erroneous store SHALL leave memory unchanged.
REQ-022 After a store accept, the FSM SHALL go directly to RESP, so resp_valid=1 one cycle after accept.
REQ-023 After a load accept:
  - If RD_LAT=1, the FSM SHALL go to RESP.
  - Otherwise it SHALL go to WAIT and count RD_LAT-1 cycles before entering RESP.
  - resp_valid SHALL be 1 exactly RD_LAT cycles after accept.
REQ-024 Load data SHALL be the addressed word as it stood at the accept edge, lane-shifted to bit 0:
  - B and H: sign-extended.
  - BU and HU: zero-extended.
  - W: unchanged.
REQ-025 An erroneous load SHALL follow the same latency as a legal load, with resp_err=1 and resp_rdata=0.
REQ-026 resp_valid, resp_rdata and resp_err SHALL be registered outputs, held stable in RESP until resp_ready=1.
REQ-027 In RESP, a cycle with resp_ready=1 SHALL return the FSM to IDLE and clear resp_valid on that edge; no new request is accepted on the same edge.
REQ-028 Addresses SHALL wrap modulo DEPTH words; no out-of-range error is raised.
REQ-029 There is no combinational path from req_* inputs to resp_* outputs.
REQ-030 Memory contents SHALL be undefined at power-up, except that the bench may preload them through initial contents.

Reset
REQ-031 While rst=1 at a rising edge, the block SHALL set:
  - state = IDLE, wait counter = 0.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - req_ready = 1 from the following cycle.
REQ-032 Reset SHALL NOT alter memory contents.
REQ-033 A load in WAIT or RESP when reset asserts SHALL be dropped with no response.
REQ-034 A store already accepted before reset asserts SHALL remain written.
REQ-035 A request presented together with rst=1 SHALL NOT be accepted, and it SHALL NOT write memory.

Verification
REQ-036 Preload word 0 = 0x00FF0FF0; LB from byte address 1 -> resp_rdata = 0x0000000F; LBU from byte address 2 -> 0x000000FF; LH from byte address 2 -> 0x000000FF.
REQ-037 Preload word 2 = 0xAA22CC33; SB 0x5A to byte address 9, then LW from byte address 8 -> 0xAA225A33 with resp_err=0.
REQ-038 LW from byte address 6 -> resp_err=1 and resp_rdata=0; SH from byte address 3 -> resp_err=1 and the target word is unchanged.
REQ-039 With RD_LAT=3, a load accepted in cycle T -> resp_valid rises in cycle T+3; with resp_ready held at 0 for 5 cycles, outputs stay stable and req_ready stays 0.
REQ-040 With rst asserted while a load is in WAIT -> no response is produced, and req_ready=1 in the cycle after rst is released.
REQ-041 With DEPTH=64, LW from byte address 0x100+0xB4 truncated to 8 bits -> returns word 45 (0xBBBBBBBB if preloaded).
